// File: rtl/bicubic_upscale_top.sv
// -----------------------------------------------------------------------------
// bicubic_upscale_top
//
// 4x bicubic upscaler for 24-bit RGB frames. One full source frame is loaded
// into an internal frame buffer, then 16 interpolated pixels are produced per
// source pixel in block-raster order (source y, source x, sub-row j, sub-col i).
//
// Parameters:
//   IMG_W, IMG_H      source frame size in pixels (each at least 2)
//
// Ports:
//   clk               clock, rising edge
//   rst_n             synchronous active-low reset
//   upsp_ac_rready    ready to accept a source pixel (high only while loading)
//   ac_upsp_rdata     source pixel, R=[23:16] G=[15:8] B=[7:0]
//   ac_upsp_rvalid    source pixel valid
//   ac_upsp_wready    downstream ready for an output pixel
//   upsp_ac_wdata     interpolated output pixel, same packing
//   upsp_ac_wvalid    output pixel valid
//   bicubic_bypass    (only with BICUBIC_BYPASS_EN) nearest-neighbour select
//
// Optional feature macro: BICUBIC_BYPASS_EN
//   When defined, the bicubic_bypass input is present; with bypass=1 every
//   output pixel of a block is the source pixel (y,x). When undefined the
//   port is absent and the output is always bicubic.
// -----------------------------------------------------------------------------
module bicubic_upscale_top #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        upsp_ac_rready,
    input  logic [23:0] ac_upsp_rdata,
    input  logic        ac_upsp_rvalid,
    input  logic        ac_upsp_wready,
    output logic [23:0] upsp_ac_wdata,
    output logic        upsp_ac_wvalid
`ifdef BICUBIC_BYPASS_EN
    ,
    input  logic        bicubic_bypass
`endif
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);

    typedef enum logic {
        ST_LOAD,
        ST_CALC
    } state_t;

    state_t              state_q;
    logic                rready_q;
    logic                wvalid_q;
    logic [23:0]         wdata_q;
    logic                done_q;
    logic [AW-1:0]       ld_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [1:0]          i_q;
    logic [1:0]          j_q;

    logic [23:0]         fb_mem [NPIX];

    logic                rd_acc;
    logic                load_en;

    // Interpolation datapath
    int                  win_r [4];
    int                  win_c [4];
    logic [7:0]          smp;
    logic signed [17:0]  hsum;
    logic signed [27:0]  vsum;
    logic [23:0]         pix_d;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Catmull-Rom style weights (a=-0.5) scaled by 128; tap 0..3 = offset -1..+2.
    function automatic logic signed [8:0] tap_wt(input logic [1:0] ph, input logic [1:0] tap);
        logic [3:0] sel;
        sel = {ph, tap};
        case (sel)
            4'h1:    return 9'sd128;
            4'h4:    return -9'sd9;
            4'h5:    return 9'sd111;
            4'h6:    return 9'sd29;
            4'h7:    return -9'sd3;
            4'h8:    return -9'sd8;
            4'h9:    return 9'sd72;
            4'hA:    return 9'sd72;
            4'hB:    return -9'sd8;
            4'hC:    return -9'sd3;
            4'hD:    return 9'sd29;
            4'hE:    return 9'sd111;
            4'hF:    return -9'sd9;
            default: return 9'sd0;
        endcase
    endfunction

    function automatic logic signed [17:0] sx18(input logic signed [8:0] v);
        return {{9{v[8]}}, v};
    endfunction

    function automatic logic signed [27:0] sx28_w(input logic signed [8:0] v);
        return {{19{v[8]}}, v};
    endfunction

    function automatic logic signed [27:0] sx28_h(input logic signed [17:0] v);
        return {{10{v[17]}}, v};
    endfunction

    // Edge replication: window coordinates outside the frame reuse the border.
    function automatic int clamp_idx(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] fb_addr(input int r, input int c);
        return AW'(r * IMG_W + c);
    endfunction

    // Total weight scale is 128*128 = 2^14; round half up, then saturate to 8 bits.
    function automatic logic [7:0] round_sat(input logic signed [27:0] s);
        logic signed [27:0] r;
        r = (s + 28'sd8192) >>> 14;
        if (r < 28'sd0) begin
            return 8'd0;
        end else if (r > 28'sd255) begin
            return 8'hFF;
        end
        return r[7:0];
    endfunction

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign rd_acc  = (state_q == ST_LOAD) && rready_q && ac_upsp_rvalid;
    assign load_en = !wvalid_q || ac_upsp_wready;

    // -------------------------------------------------------------------------
    // Frame buffer write (data only, no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fb_mem[ld_q] <= ac_upsp_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Interpolated pixel for the current iterator position
    // -------------------------------------------------------------------------
    always_comb begin
        pix_d = '0;
        smp   = '0;
        hsum  = '0;
        vsum  = '0;
        for (int k = 0; k < 4; k++) begin
            win_r[k] = clamp_idx(int'(y_q) - 1 + k, IMG_H - 1);
            win_c[k] = clamp_idx(int'(x_q) - 1 + k, IMG_W - 1);
        end
        for (int ch = 0; ch < 3; ch++) begin
            vsum = '0;
            for (int r = 0; r < 4; r++) begin
                hsum = '0;
                for (int c = 0; c < 4; c++) begin
                    smp  = fb_mem[fb_addr(win_r[r], win_c[c])][ch*8 +: 8];
                    hsum = hsum + $signed({10'b0, smp}) * sx18(tap_wt(i_q, 2'(c)));
                end
                vsum = vsum + sx28_h(hsum) * sx28_w(tap_wt(j_q, 2'(r)));
            end
            pix_d[ch*8 +: 8] = round_sat(vsum);
        end
`ifdef BICUBIC_BYPASS_EN
        if (bicubic_bypass) begin
            pix_d = fb_mem[fb_addr(int'(y_q), int'(x_q))];
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Control FSM, iterator and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            rready_q <= 1'b0;
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            ld_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    rready_q <= 1'b1;
                    if (rd_acc) begin
                        if (ld_q == AW'(NPIX - 1)) begin
                            state_q  <= ST_CALC;
                            rready_q <= 1'b0;
                            ld_q     <= '0;
                        end else begin
                            ld_q <= ld_q + AW'(1);
                        end
                    end
                end
                ST_CALC: begin
                    if (load_en) begin
                        if (!done_q) begin
                            wdata_q  <= pix_d;
                            wvalid_q <= 1'b1;
                            // i fastest, then j, then x, then y; all wrap to 0
                            // on the final position so only done_q remains set.
                            if (i_q != 2'd3) begin
                                i_q <= i_q + 2'd1;
                            end else begin
                                i_q <= 2'd0;
                                if (j_q != 2'd3) begin
                                    j_q <= j_q + 2'd1;
                                end else begin
                                    j_q <= 2'd0;
                                    if (x_q != XW'(IMG_W - 1)) begin
                                        x_q <= x_q + XW'(1);
                                    end else begin
                                        x_q <= '0;
                                        if (y_q != YW'(IMG_H - 1)) begin
                                            y_q <= y_q + YW'(1);
                                        end else begin
                                            y_q    <= '0;
                                            done_q <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end else begin
                            // Last pixel was just handed off: frame complete.
                            wvalid_q <= 1'b0;
                            done_q   <= 1'b0;
                            state_q  <= ST_LOAD;
                            rready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign upsp_ac_rready = rready_q;
    assign upsp_ac_wdata  = wdata_q;
    assign upsp_ac_wvalid = wvalid_q;

endmodule

// File: tb/tb_bicubic_upscale_top.sv
// -----------------------------------------------------------------------------
// tb_bicubic_upscale_top
//
// Directed bench for bicubic_upscale_top (8x8 source). Loads constant, step and
// ramp frames, captures the 1024-pixel outputs and compares against hand
// computed values and a wready=1 reference run.
// -----------------------------------------------------------------------------
module tb_bicubic_upscale_top;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = 16 * NPIX;

    logic        clk;
    logic        rst_n;
    logic        rready;
    logic [23:0] rdata;
    logic        rvalid;
    logic        wready;
    logic [23:0] wdata;
    logic        wvalid;
`ifdef BICUBIC_BYPASS_EN
    logic        bicubic_bypass;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] cap   [NOUT];
    logic [23:0] ref_c [NOUT];
    int          cap_n;
    int          first_cyc;
    int          last_cyc;
    int          hold_err;
    int          early_out;

    bicubic_upscale_top #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upsp_ac_rready (rready),
        .ac_upsp_rdata  (rdata),
        .ac_upsp_rvalid (rvalid),
        .ac_upsp_wready (wready),
        .upsp_ac_wdata  (wdata),
        .upsp_ac_wvalid (wvalid)
`ifdef BICUBIC_BYPASS_EN
        ,
        .bicubic_bypass (bicubic_bypass)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] src_pix(input int kind, input int idx);
        int r;
        int c;
        r = idx / W;
        c = idx % W;
        case (kind)
            0:       return 24'h808080;
            1:       return (c < 2) ? 24'h000000 : 24'hFFFFFF;
            default: return {8'(c * 32), 8'(r * 32), 8'((r * 8 + c) * 4)};
        endcase
    endfunction

    function automatic int oi(input int y, input int x, input int j, input int i);
        return (y * W + x) * 16 + j * 4 + i;
    endfunction

    // Inputs change only on negedges; an accept happens at the following posedge.
    task automatic load_frame(input int kind);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        while (idx < NPIX && guard < 5000) begin
            @(negedge clk);
            if (wvalid) early_out++;
            rdata  = src_pix(kind, idx);
            rvalid = 1'b1;
            if (rready) begin
                @(posedge clk);
                idx++;
            end else begin
                guard++;
            end
        end
        chk("load_count", 32'(idx), 32'(NPIX));
        @(negedge clk);
        rvalid = 1'b0;
        chk("rready_after_load", 32'(rready), 32'd0);
    endtask

    task automatic collect(input int limit, input bit rnd);
        int          cyc;
        bit          prev_hold;
        logic [23:0] prev;
        cyc       = 0;
        prev_hold = 1'b0;
        prev      = '0;
        cap_n     = 0;
        hold_err  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (cap_n < limit && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_hold && (!wvalid || wdata !== prev)) hold_err++;
            wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid && wready) begin
                if (cap_n == 0) first_cyc = cyc;
                last_cyc   = cyc;
                cap[cap_n] = wdata;
                cap_n++;
            end
            prev_hold = wvalid && !wready;
            prev      = wdata;
        end
        chk("collect_count", 32'(cap_n), 32'(limit));
    endtask

    initial begin
        int bad;
        rst_n  = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        wready = 1'b0;
        early_out = 0;
`ifdef BICUBIC_BYPASS_EN
        bicubic_bypass = 1'b0;
`endif

        // Reset behaviour
        repeat (2) @(posedge clk);
        #1;
        chk("rready_in_reset", 32'(rready), 32'd0);
        chk("wvalid_in_reset", 32'(wvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rready_after_rel", 32'(rready), 32'd1);
        chk("wvalid_after_rel", 32'(wvalid), 32'd0);
        chk("wdata_after_rel", 32'(wdata), 32'd0);
        repeat (10) begin
            @(negedge clk);
            if (wvalid) early_out++;
        end

        // Constant frame
        load_frame(0);
        chk("no_output_before_load", 32'(early_out), 32'd0);
        collect(NOUT, 1'b0);
        bad = 0;
        for (int k = 0; k < NOUT; k++) if (cap[k] !== 24'h808080) bad++;
        chk("const_values", 32'(bad), 32'd0);
        chk("const_back_to_back", 32'(last_cyc - first_cyc), 32'(NOUT - 1));
        repeat (2) @(negedge clk);
        chk("const_wvalid_end", 32'(wvalid), 32'd0);
        chk("const_rready_end", 32'(rready), 32'd1);

        // Horizontal step frame
        load_frame(1);
        collect(NOUT, 1'b0);
        chk("step_x1_i0", 32'(cap[oi(0, 1, 0, 0)]), 32'h000000);
        chk("step_x1_i1", 32'(cap[oi(0, 1, 0, 1)]), 32'h343434);
        chk("step_x1_i2", 32'(cap[oi(0, 1, 0, 2)]), 32'h808080);
        chk("step_x1_i3", 32'(cap[oi(0, 1, 0, 3)]), 32'hCBCBCB);
        chk("step_x1_j2_i3", 32'(cap[oi(0, 1, 2, 3)]), 32'hCBCBCB);
        chk("step_x2_i0", 32'(cap[oi(0, 2, 0, 0)]), 32'hFFFFFF);
        chk("step_x2_i1_sat", 32'(cap[oi(0, 2, 0, 1)]), 32'hFFFFFF);
        chk("step_x0_i3_neg", 32'(cap[oi(0, 0, 0, 3)]), 32'h000000);

        // Ramp frame, reference run
        load_frame(2);
        collect(NOUT, 1'b0);
        for (int k = 0; k < NOUT; k++) ref_c[k] = cap[k];
        chk("ramp_y3x3_i2", 32'(ref_c[oi(3, 3, 0, 2)]), 32'h70606E);
        chk("ramp_y3x3_i0", 32'(ref_c[oi(3, 3, 0, 0)]), 32'h60606C);

        // Ramp frame under random backpressure
        load_frame(2);
        collect(NOUT, 1'b1);
        bad = 0;
        for (int k = 0; k < NOUT; k++) if (cap[k] !== ref_c[k]) bad++;
        chk("bp_sequence", 32'(bad), 32'd0);
        chk("bp_hold_stable", 32'(hold_err), 32'd0);

        // Reset in the middle of CALC
        load_frame(1);
        collect(100, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_wvalid", 32'(wvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(2);
        collect(NOUT, 1'b0);
        bad = 0;
        for (int k = 0; k < NOUT; k++) if (cap[k] !== ref_c[k]) bad++;
        chk("midreset_frame", 32'(bad), 32'd0);

`ifdef BICUBIC_BYPASS_EN
        // Nearest-neighbour bypass on the step frame
        bicubic_bypass = 1'b1;
        load_frame(1);
        collect(NOUT, 1'b0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (cap[oi(0, 1, 0, 0) + k] !== 24'h000000) bad++;
            if (cap[oi(0, 2, 0, 0) + k] !== 24'hFFFFFF) bad++;
        end
        chk("bypass_blocks", 32'(bad), 32'd0);
        bicubic_bypass = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bicubic_upscale_top.md
Name: bicubic_upscale_top

Overview:
4x bicubic upscaler for 24-bit RGB frames. It sits between the access controller's read stream (ac_upsp_*) and write stream (upsp_ac_*). It buffers one full source frame, then emits 16 interpolated output pixels per source pixel, one 24-bit pixel per handshake. Output order is block-raster.

Parameters:
IMG_W, 8, source frame width in pixels (at least 2)
IMG_H, 8, source frame height in pixels (at least 2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
upsp_ac_rready  output  1  ready to accept a source pixel
ac_upsp_rdata  input  24  source pixel; R=[23:16], G=[15:8], B=[7:0]
ac_upsp_rvalid  input  1  source pixel valid
ac_upsp_wready  input  1  downstream ready for an output pixel
upsp_ac_wdata  output  24  interpolated output pixel, same channel packing
upsp_ac_wvalid  output  1  output pixel valid

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state=LOAD; all counters 0; upsp_ac_wvalid=0; upsp_ac_wdata=0; upsp_ac_rready=0 in the reset cycle, 1 from the first cycle after reset release.
- Reset asserted mid-frame: discards the partial frame and any pending output; returns to LOAD.
- State LOAD:
  - upsp_ac_rready=1.
  - Each cycle with rvalid&rready stores rdata at frame buffer index (row*IMG_W+col), raster order.
  - After IMG_W*IMG_H accepts, go to CALC. rready drops in the cycle after the last accept.
  - No input is accepted outside LOAD.
- State CALC:
  - Iterates source y (0..H-1), then x (0..W-1), then sub-row j (0..3), then sub-col i (0..3); i is fastest.
  - Output pixel (4y+j, 4x+i) has phase (j/4, i/4). Phase 0 aligns with the source pixel.
  - Window: rows y-1..y+2 and cols x-1..x+2, each clamped to [0,H-1] / [0,W-1] (edge replicate).
  - Weights (a=-0.5, scaled by 128), taps ordered -1, 0, +1, +2:
    - phase0 = 0, 128, 0, 0
    - phase1 = -9, 111, 29, -3
    - phase2 = -8, 72, 72, -8
    - phase3 = -3, 29, 111, -9
  - Per channel: horizontal 4-tap sum per window row (signed, at least 17 bits), then vertical 4-tap sum on those results (signed, at least 26 bits).
  - Result = (sum + 8192) >>> 14 (arithmetic shift), clamped to 0..255.
- Output handshake:
  - Output register loads a new pixel when (!wvalid || wready). Latency is 1 cycle from the iterator position to wvalid.
  - While wvalid=1 and wready=0, wdata and wvalid hold stable. The iterator does not advance.
  - Sustained throughput is 1 pixel per cycle when wready=1.
- Frame end: after the 16*W*H-th output handshake, return to LOAD with counters cleared. The next frame may start immediately.
- Total outputs per frame: exactly 16*IMG_W*IMG_H.

Optional Feature:
- Macro BICUBIC_BYPASS_EN.
- Defined: adds input port bicubic_bypass (1 bit, sampled per output pixel). When bicubic_bypass=1, output = source pixel (y,x) replicated into all 16 positions (nearest neighbour). Timing and handshake are unchanged.
- Undefined: no bicubic_bypass port; always bicubic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> wvalid=0, wdata=0, rready=1 one cycle after release; no output until 64 pixels are loaded.
- Constant frame: 64 pixels of 0x808080, wready=1 -> exactly 1024 outputs, all 0x808080, back-to-back. rready returns to 1 afterwards.
- Horizontal step, all rows identical: cols 0,1 = 0x000000 and cols 2..7 = 0xFFFFFF, at block (y=0, x=1):
  - i=2 -> 0x808080
  - i=3 -> 0xCBCBCB
  - at x=2, i=1 -> clamp to 0xFFFFFF (raw value 273)
  - i=0 -> exact source pixel
- Backpressure: random wready (about 50%) on the ramp frame -> output sequence identical to the wready=1 run; wdata stable whenever wvalid&!wready.
- Reset mid-CALC after 100 outputs -> wvalid low next cycle. A fresh 64-pixel load then produces a complete correct 1024-pixel frame.
- BICUBIC_BYPASS_EN with bicubic_bypass=1 on the step frame -> all 16 pixels of block (0,1) = 0x000000 and all of block (0,2) = 0xFFFFFF.
